// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake, DATA/CTRL split,
// optional two-slot skid buffer so in_ready comes from flops only.
module pipe_stage_elastic #(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter bit                SKID     = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } slot_t;

  slot_t      h_q, h_d;
  slot_t      s_q, s_d;
  slot_t      beat;
  logic [1:0] occ_q, occ_d;
  logic       in_fire;
  logic       out_fire;

  // An emptied slot keeps its data but always carries a NOP control word.
  function automatic slot_t drop(input slot_t s);
    slot_t r;
    r      = s;
    r.vld  = 1'b0;
    r.ctrl = CTRL_NOP;
    return r;
  endfunction

  // Incoming beat packed as a slot, plus handshake qualifiers.
  always_comb begin
    beat      = '{vld: 1'b1, data: in_data, ctrl: in_ctrl};
    in_ready  = SKID ? !s_q.vld : (!h_q.vld | out_ready);
    in_fire   = in_valid & in_ready;
    out_fire  = h_q.vld & out_ready;
  end

  // Next-state for head and skid slots; flush outranks every transfer.
  always_comb begin
    h_d = h_q;
    s_d = s_q;
    if (flush) begin
      h_d = drop(h_q);
      s_d = drop(s_q);
    end else if (!SKID) begin
      if (in_fire) begin
        h_d = beat;
      end else if (out_fire) begin
        h_d = drop(h_q);
      end
    end else begin
      unique case (1'b1)
        !h_q.vld: begin
          if (in_fire) h_d = beat;
        end
        out_fire && s_q.vld: begin
          h_d = s_q;
          s_d = drop(s_q);
        end
        out_fire && !s_q.vld: begin
          h_d = in_fire ? beat : drop(h_q);
        end
        default: begin
          if (in_fire) s_d = beat;
        end
      endcase
    end
    occ_d = {1'b0, h_d.vld} + {1'b0, s_d.vld};
  end

  // Slot and occupancy registers; async reset leaves both slots as bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q   <= '{vld: 1'b0, data: '0, ctrl: CTRL_NOP};
      s_q   <= '{vld: 1'b0, data: '0, ctrl: CTRL_NOP};
      occ_q <= 2'd0;
    end else begin
      h_q   <= h_d;
      s_q   <= s_d;
      occ_q <= occ_d;
    end
  end

  // Outputs come straight from the head slot flops.
  always_comb begin
    out_valid = h_q.vld;
    out_data  = h_q.data;
    out_ctrl  = h_q.ctrl;
    occupancy = occ_q;
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: one SKID=1 and one SKID=0 instance on
// shared inputs, directed vectors then a random run against queue models.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_data;
  logic [15:0] in_ctrl;

  logic        ir1, ov1, ir0, ov0;
  logic [63:0] od1, od0;
  logic [15:0] oc1, oc0;
  logic [1:0]  occ1, occ0;

  int n_tot = 0;
  int n_bad = 0;

  logic [79:0] q1[$];
  logic [79:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_elastic #(.SKID(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_ctrl(oc1), .occupancy(occ1)
  );

  pipe_stage_elastic #(.SKID(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_ctrl(oc0), .occupancy(occ0)
  );

  task automatic chk(input string tag,
                     input logic [79:0] got,
                     input logic [79:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk_ctrl(input logic [63:0] d);
    return {8'hC0, d[7:0]};
  endfunction

  task automatic put(input logic v, input logic [63:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = mk_ctrl(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    put(1'b0, 64'd0);
    flush     = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #2;
    reset_n   = 1'b1;
    step();
  endtask

  task automatic sb(input bit k, input logic ir, input logic ov,
                    input logic [63:0] od, input logic [15:0] oc,
                    input logic [1:0] occ);
    int          sz;
    logic [79:0] hd;
    logic        ir_exp;
    hd = '0;
    sz = k ? q1.size() : q0.size();
    if (sz != 0) hd = k ? q1[0] : q0[0];
    ir_exp = k ? (sz < 2) : (sz == 0 || out_ready);
    chk("rnd_vld", 80'(ov), 80'(sz != 0));
    chk("rnd_occ", 80'(occ), 80'(sz));
    chk("rnd_rdy", 80'(ir), 80'(ir_exp));
    if (sz != 0) chk("rnd_head", {od, oc}, hd);
    else chk("rnd_nop", 80'(oc), 80'd0);
    if (sz != 0 && out_ready) begin
      if (k) void'(q1.pop_front());
      else void'(q0.pop_front());
    end
    if (flush) begin
      if (k) q1.delete();
      else q0.delete();
    end else if (in_valid && ir) begin
      if (k) q1.push_back({in_data, in_ctrl});
      else q0.push_back({in_data, in_ctrl});
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    put(1'b1, 64'hAA);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 80'(ov1), 80'd0);
    chk("rst_ctrl", 80'(oc1), 80'd0);
    chk("rst_data", 80'(od1), 80'd0);
    chk("rst_occ", 80'(occ1), 80'd0);
    chk("rst_rdy", 80'(ir1), 80'd1);
    chk("rst_vld0", 80'(ov0), 80'd0);
    chk("rst_rdy0", 80'(ir0), 80'd1);

    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      put(1'b1, 64'(i));
      chk("str_rdy1", 80'(ir1), 80'd1);
      chk("str_rdy0", 80'(ir0), 80'd1);
      step();
      chk("str_d1", {15'd0, ov1, od1}, {15'd0, 1'b1, 64'(i)});
      chk("str_d0", {15'd0, ov0, od0}, {15'd0, 1'b1, 64'(i)});
      chk("str_c1", 80'(oc1), 80'(mk_ctrl(64'(i))));
    end
    put(1'b0, 64'd0);
    step();
    chk("str_end", 80'(ov1), 80'd0);
    chk("str_endc", 80'(oc1), 80'd0);

    do_reset();
    put(1'b1, 64'h11);
    step();
    chk("bp_occ1", 80'(occ1), 80'd1);
    chk("bp_rdy1", 80'(ir1), 80'd1);
    put(1'b1, 64'h22);
    step();
    put(1'b0, 64'd0);
    chk("bp_occ2", 80'(occ1), 80'd2);
    chk("bp_rdy0", 80'(ir1), 80'd0);
    chk("bp_head", 80'(od1), 80'h11);
    step();
    chk("bp_hold", {15'd0, ov1, od1}, {15'd0, 1'b1, 64'h11});
    out_ready = 1'b1;
    #1;
    chk("bp_pop1", 80'(od1), 80'h11);
    step();
    chk("bp_pop2", 80'(od1), 80'h22);
    chk("bp_occ", 80'(occ1), 80'd1);
    chk("bp_rdy", 80'(ir1), 80'd1);
    step();
    chk("bp_empty", 80'(ov1), 80'd0);
    chk("bp_occ0", 80'(occ1), 80'd0);

    do_reset();
    put(1'b1, 64'h11);
    step();
    put(1'b1, 64'h22);
    step();
    flush = 1'b1;
    put(1'b1, 64'h33);
    step();
    flush = 1'b0;
    put(1'b0, 64'd0);
    chk("fl_occ", 80'(occ1), 80'd0);
    chk("fl_vld", 80'(ov1), 80'd0);
    chk("fl_ctrl", 80'(oc1), 80'd0);
    chk("fl_data", 80'(od1), 80'h11);
    chk("fl_rdy", 80'(ir1), 80'd1);
    out_ready = 1'b1;
    step();
    chk("fl_gone", 80'(ov1), 80'd0);
    put(1'b1, 64'h44);
    step();
    put(1'b0, 64'd0);
    chk("fl_next", {15'd0, ov1, od1}, {15'd0, 1'b1, 64'h44});
    step();
    out_ready = 1'b0;
    put(1'b1, 64'h55);
    step();
    flush = 1'b1;
    put(1'b1, 64'h66);
    chk("fl1_rdy", 80'(ir1), 80'd1);
    step();
    flush = 1'b0;
    put(1'b0, 64'd0);
    chk("fl1_occ", 80'(occ1), 80'd0);
    chk("fl1_data", 80'(od1), 80'h55);
    out_ready = 1'b1;
    step();
    chk("fl1_gone", 80'(ov1), 80'd0);

    do_reset();
    put(1'b1, 64'h11);
    step();
    put(1'b1, 64'h22);
    step();
    put(1'b0, 64'd0);
    reset_n = 1'b0;
    #1;
    chk("ar_occ", 80'(occ1), 80'd0);
    chk("ar_vld", 80'(ov1), 80'd0);
    chk("ar_rdy", 80'(ir1), 80'd1);
    reset_n = 1'b1;
    put(1'b1, 64'h77);
    step();
    put(1'b0, 64'd0);
    chk("ar_first", {14'd0, occ1, od1}, {14'd0, 2'd1, 64'h77});

    do_reset();
    put(1'b1, 64'h11);
    step();
    chk("s0_h", {15'd0, ov0, od0}, {15'd0, 1'b1, 64'h11});
    put(1'b1, 64'h22);
    #1;
    chk("s0_rdy0", 80'(ir0), 80'd0);
    out_ready = 1'b1;
    #1;
    chk("s0_rdy1", 80'(ir0), 80'd1);
    step();
    put(1'b0, 64'd0);
    chk("s0_new", {15'd0, ov0, od0}, {15'd0, 1'b1, 64'h22});
    chk("s0_occ", 80'(occ0), 80'd1);

    do_reset();
    q1.delete();
    q0.delete();
    for (int c = 0; c < 10000; c++) begin
      flush     = ($urandom_range(63) == 0);
      out_ready = ($urandom_range(9) < 6);
      put($urandom_range(9) < 7, {$urandom(), $urandom()});
      #2;
      sb(1'b1, ir1, ov1, od1, oc1, occ1);
      sb(1'b0, ir0, ov0, od0, oc0, occ0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
